// File: rtl/covid_pio_scan_ctrl.sv
// covid_pio_scan_ctrl
//   Periodically polls bit 0 of an input-PIO slave, debounces the sampled
//   level and reports accepted level changes as pulses, a sticky irq and an
//   optional saturating event counter.
//
// Parameters
//   SCAN_PERIOD   clock cycles between scan starts (4..65535)
//   DEBOUNCE_CNT  consecutive differing samples to accept a change (1..15)
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   enable        high permits new scans
//   irq_ack       one-cycle pulse clearing irq
//   pio_address   address to the polled PIO slave (0 while selecting, 1 parked)
//   pio_readdata  registered slave read data, 1-cycle latency, bit 0 used
//   level         debounced input level
//   rise_pulse    one-cycle pulse on accepted 0->1
//   fall_pulse    one-cycle pulse on accepted 1->0
//   sample_valid  one-cycle pulse per raw sample taken
//   irq           sticky event flag
//   event_count   accepted-change counter
//
// Build option
//   COVID_PIO_SCAN_CNT_EN  when defined, event_count counts accepted changes
//                          (saturating); otherwise it is tied to 0.

module covid_pio_scan_ctrl #(
    parameter int unsigned SCAN_PERIOD  = 50000,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        irq_ack,
    output logic [1:0]  pio_address,
    input  logic [31:0] pio_readdata,
    output logic        level,
    output logic        rise_pulse,
    output logic        fall_pulse,
    output logic        sample_valid,
    output logic        irq,
    output logic [15:0] event_count
);

    localparam logic [15:0] TIMER_LAST = 16'(SCAN_PERIOD - 1);
    localparam logic [3:0]  DEB_LIMIT  = 4'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEL,
        ST_WAIT,
        ST_SAMPLE
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  diff_q, diff_d;
    logic        level_q, level_d;
    logic        rise_q, rise_d;
    logic        fall_q, fall_d;
    logic        irq_q, irq_d;
    logic        change;

    // Only bit 0 of the slave data carries the polled input.
    logic unused_readdata;
    assign unused_readdata = ^pio_readdata[31:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            diff_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            diff_q  <= diff_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pio_address  = 2'd1;
        sample_valid = 1'b0;
        timer_d      = '0;
        diff_d       = diff_q;
        level_d      = level_q;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        change       = 1'b0;

        if (enable) begin
            timer_d = (timer_q == TIMER_LAST) ? '0 : timer_q + 16'd1;
        end

        // Only the launch out of IDLE looks at enable, so a scan already
        // under way always runs through SAMPLE.
        unique case (state_q)
            ST_IDLE: begin
                if (enable && (timer_q == TIMER_LAST)) state_d = ST_SEL;
            end
            ST_SEL: begin
                pio_address = 2'd0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                pio_address = 2'd0;
                state_d     = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                sample_valid = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q == ST_SAMPLE) begin
            if (pio_readdata[0] == level_q) begin
                diff_d = '0;
            end else if ((diff_q + 4'd1) == DEB_LIMIT) begin
                change  = 1'b1;
                level_d = ~level_q;
                diff_d  = '0;
                rise_d  = ~level_q;
                fall_d  = level_q;
            end else begin
                diff_d = diff_q + 4'd1;
            end
        end

        // A new event wins over an acknowledge arriving on the same edge.
        irq_d = change ? 1'b1 : (irq_ack ? 1'b0 : irq_q);
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign irq        = irq_q;

`ifdef COVID_PIO_SCAN_CNT_EN
    logic [15:0] event_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            event_cnt_q <= '0;
        end else if (change && (event_cnt_q != '1)) begin
            event_cnt_q <= event_cnt_q + 16'd1;
        end
    end

    assign event_count = event_cnt_q;
`else
    assign event_count = '0;
`endif

endmodule

// File: tb/tb_covid_pio_scan_ctrl.sv
// tb_covid_pio_scan_ctrl
//   Self-checking bench for covid_pio_scan_ctrl with SCAN_PERIOD=8 and
//   DEBOUNCE_CNT=3: reset values, scan cadence, a per-scan vector table for
//   debounce / glitch / irq-ack behaviour, enable-drop and reset-in-SEL
//   sequences, then randomized stimulus against a behavioural model.
//   event_count expectations follow COVID_PIO_SCAN_CNT_EN.

module tb_covid_pio_scan_ctrl;

    localparam int P   = 8;
    localparam int DEB = 3;
`ifdef COVID_PIO_SCAN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        irq_ack = 1'b0;
    logic [31:0] pio_readdata = '0;
    logic [1:0]  pio_address;
    logic        level, rise_pulse, fall_pulse, sample_valid, irq;
    logic [15:0] event_count;

    int n_checks = 0;
    int n_errors = 0;

    covid_pio_scan_ctrl #(
        .SCAN_PERIOD  (P),
        .DEBOUNCE_CNT (DEB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .irq_ack      (irq_ack),
        .pio_address  (pio_address),
        .pio_readdata (pio_readdata),
        .level        (level),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .sample_valid (sample_valid),
        .irq          (irq),
        .event_count  (event_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic int expc(int c);
        return CNT_EN ? c : 0;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(bit b);
        pio_readdata = {31'($urandom()), b};
    endtask

    // Advance until sample_valid is seen (at most 20 cycles).
    task automatic wait_sv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sample_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Advance until pio_address==0 (the SEL cycle) is seen.
    task automatic wait_sel(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pio_address == 2'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // m_age: -1 when no scan is running, else cycles since the scan started.
    int m_tmod, m_age, m_cnt;
    bit m_level, m_rise, m_fall, m_irq;
    bit hist[$];

    task automatic model_reset();
        m_tmod = 0; m_age = -1; m_cnt = 0;
        m_level = 0; m_rise = 0; m_fall = 0; m_irq = 0;
        hist.delete();
    endtask

    task automatic model_step(bit rst, bit en, bit ack, bit rd);
        int old_age;
        int nd;
        bit chg;
        if (rst) begin
            model_reset();
            return;
        end
        old_age = m_age;
        chg = 0;
        m_rise = 0;
        m_fall = 0;
        if (old_age == 2) begin
            // Accept a change once the last DEB samples all disagree with level.
            hist.push_back(rd);
            if (hist.size() > DEB) void'(hist.pop_front());
            nd = 0;
            foreach (hist[i]) if (hist[i] != m_level) nd++;
            if (nd == DEB) begin
                chg = 1;
                m_level = ~m_level;
                m_rise = m_level;
                m_fall = ~m_level;
                hist.delete();
                if (m_cnt < 65535) m_cnt++;
            end
        end
        m_irq = chg ? 1'b1 : (ack ? 1'b0 : m_irq);
        if (old_age < 0) m_age = (en && m_tmod == P - 1) ? 0 : -1;
        else if (old_age == 2) m_age = -1;
        else m_age = old_age + 1;
        m_tmod = en ? (m_tmod + 1) % P : 0;
    endtask

    function automatic logic [22:0] model_out();
        logic [1:0] a;
        a = (m_age == 0 || m_age == 1) ? 2'd0 : 2'd1;
        return {a, m_level, m_rise, m_fall, (m_age == 2), m_irq, 16'(expc(m_cnt))};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        bit rd;
        bit ack;
        bit lvl;
        bit rise;
        bit fall;
        bit irq;
        int cnt;
    } vec_t;

    vec_t tbl[17];

    initial begin
        bit ok;
        int k, first_sv, second_sv, addr0;
        bit bad;

        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 0, 1, 1, 0, 1, 1};
        tbl[9]  = '{1, 1, 1, 0, 0, 0, 1};
        tbl[10] = '{0, 0, 1, 0, 0, 0, 1};
        tbl[11] = '{0, 0, 1, 0, 0, 0, 1};
        tbl[12] = '{0, 1, 0, 0, 1, 1, 2};
        tbl[13] = '{0, 1, 0, 0, 0, 0, 2};
        tbl[14] = '{1, 0, 0, 0, 0, 0, 2};
        tbl[15] = '{1, 0, 0, 0, 0, 0, 2};
        tbl[16] = '{1, 0, 1, 1, 0, 1, 3};

        // ---- reset state ----
        reset = 1'b1;
        enable = 1'b1;
        set_rd(1'b0);
        tick();
        tick();
        check("reset_addr",  32'(pio_address), 32'd1);
        check("reset_sv",    32'(sample_valid), 32'd0);
        check("reset_level", 32'(level), 32'd0);
        check("reset_pulse", 32'({rise_pulse, fall_pulse}), 32'd0);
        check("reset_irq",   32'(irq), 32'd0);
        check("reset_cnt",   32'(event_count), 32'd0);

        // ---- cadence ----
        reset = 1'b0;
        first_sv = -1; second_sv = -1; addr0 = 0;
        for (k = 1; k <= 20; k++) begin
            tick();
            if (pio_address == 2'd0 && first_sv < 0) addr0++;
            if (sample_valid) begin
                if (first_sv < 0) first_sv = k;
                else if (second_sv < 0) second_sv = k;
            end
        end
        check("first_sv_cycle", 32'(first_sv), 32'd10);
        check("sv_spacing", 32'(second_sv - first_sv), 32'd8);
        check("addr0_cycles", 32'(addr0), 32'd2);

        // ---- per-scan vector table ----
        foreach (tbl[i]) begin
            set_rd(tbl[i].rd);
            wait_sv(ok);
            check($sformatf("vec%0d_sv_seen", i), 32'(ok), 32'd1);
            irq_ack = tbl[i].ack;
            tick();
            irq_ack = 1'b0;
            check($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            check($sformatf("vec%0d_rise", i),  32'(rise_pulse), 32'(tbl[i].rise));
            check($sformatf("vec%0d_fall", i),  32'(fall_pulse), 32'(tbl[i].fall));
            check($sformatf("vec%0d_irq", i),   32'(irq), 32'(tbl[i].irq));
            check($sformatf("vec%0d_cnt", i),   32'(event_count), 32'(expc(tbl[i].cnt)));
            tick();
            check($sformatf("vec%0d_pulse_end", i), 32'({rise_pulse, fall_pulse}), 32'd0);
        end

        // ---- enable dropped in WAIT ----
        set_rd(1'b1);
        wait_sel(ok);
        check("en_sel_seen", 32'(ok), 32'd1);
        tick();
        check("en_wait_addr", 32'(pio_address), 32'd0);
        enable = 1'b0;
        tick();
        check("en_last_sv", 32'(sample_valid), 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (sample_valid || pio_address != 2'd1) bad = 1'b1;
        end
        check("en_off_quiet", 32'(bad), 32'd0);

        // ---- reset during SEL ----
        enable = 1'b1;
        wait_sel(ok);
        check("rst_sel_seen", 32'(ok), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_sel_out",
              32'({pio_address, level, rise_pulse, fall_pulse, sample_valid, irq}),
              32'({2'd1, 5'd0}));
        check("rst_sel_cnt", 32'(event_count), 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (sample_valid) bad = 1'b1;
        end
        check("rst_no_sample", 32'(bad), 32'd0);

        // ---- randomized run against model ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [22:0] act;
            enable  = ($urandom_range(0, 9) != 0);
            irq_ack = ($urandom_range(0, 7) == 0);
            reset   = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 19) == 0) set_rd(~pio_readdata[0]);
            else set_rd(pio_readdata[0]);
            @(posedge clk);
            model_step(reset, enable, irq_ack, pio_readdata[0]);
            #1;
            act = {pio_address, level, rise_pulse, fall_pulse, sample_valid, irq, event_count};
            check($sformatf("rand_c%0d", c), 32'(act), 32'(model_out()));
        end
        reset = 1'b0;
        irq_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
